// File: rtl/ws2812_rx_pkg.sv
// ws2812_rx_pkg: WS2812 line timing shared by the receiver and transmitter,
// plus the receiver state encoding. No ports.
package ws2812_rx_pkg;

    localparam int WS_CLK_MHZ    = 48;
    localparam int WS_T0H        = 17;
    localparam int WS_T1H        = 34;
    localparam int WS_PERIOD     = 60;
    localparam int WS_RESET_CYC  = 2400;
    localparam int WS_MIN_HIGH   = 4;
    localparam int WS_BIT_THRESH = 26;
    localparam int WS_MAX_HIGH   = 60;
    localparam int WS_WORD_BITS  = 24;

    typedef enum logic [1:0] {
        ST_WAIT_GAP,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-word bundle of the WS2812 receiver.
// rgb_data/led_index with rgb_valid strobe, frame_done and err pulses.
interface ws2812_rx_if;
    import ws2812_rx_pkg::*;

    logic [WS_WORD_BITS-1:0] rgb_data;
    logic                    rgb_valid;
    logic [7:0]              led_index;
    logic                    frame_done;
    logic                    err;

    modport master (
        output rgb_data,
        output rgb_valid,
        output led_index,
        output frame_done,
        output err
    );

    modport slave (
        input rgb_data,
        input rgb_valid,
        input led_index,
        input frame_done,
        input err
    );

endinterface

// File: rtl/ws2812_edge_sync.sv
// ws2812_edge_sync: 2-flop synchronizer for din plus edge detector.
// Ports: clk, reset (sync, active high), din -> level, rise, fall.
module ws2812_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial decoder; measures high widths into 24-bit words.
// Ports: clk, reset (sync, active high), din, rx (ws2812_rx_if.master).
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int CLK_MHZ    = WS_CLK_MHZ,
    parameter int MIN_HIGH   = WS_MIN_HIGH,
    parameter int BIT_THRESH = WS_BIT_THRESH,
    parameter int MAX_HIGH   = WS_MAX_HIGH,
    parameter int RESET_CYC  = WS_RESET_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    ws2812_rx_if.master rx
);

    localparam int CW = $clog2(RESET_CYC + 1);
    localparam int WB = WS_WORD_BITS;

    localparam logic [CW-1:0] GAP_CNT = CW'(RESET_CYC);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_HIGH);
    localparam logic [CW-1:0] THR_CNT = CW'(BIT_THRESH);
    localparam logic [CW-1:0] OVR_CNT = CW'(MAX_HIGH + 1);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);
    localparam logic [4:0]    LAST_BIT = 5'(WB - 1);

    if (CLK_MHZ < 1 || MIN_HIGH < 1 || BIT_THRESH <= MIN_HIGH ||
        MAX_HIGH < BIT_THRESH || RESET_CYC <= MAX_HIGH) begin : g_bad_param
        $error("ws2812_rx: inconsistent timing parameters");
    end

    logic level;
    logic rise;
    logic fall;

    ws2812_edge_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    rx_state_e     state,    state_n;
    logic [CW-1:0] cnt,      cnt_n;
    logic [4:0]    bit_cnt,  bit_cnt_n;
    logic [WB-1:0] shreg,    shreg_n;
    logic [WB-1:0] data_q,   data_n;
    logic          valid_q,  valid_n;
    logic [7:0]    idx_q,    idx_n;
    logic [7:0]    nidx_q,   nidx_n;
    logic          done_q,   done_n;
    logic          err_q,    err_n;

    logic [CW-1:0] cnt_inc;
    logic          bit_val;
    logic [WB-1:0] shifted;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE_CNT;
    assign bit_val = (cnt >= THR_CNT);
    assign shifted = {shreg[WB-2:0], bit_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_WAIT_GAP;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            nidx_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            idx_q   <= idx_n;
            nidx_q  <= nidx_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        data_n    = data_q;
        valid_n   = 1'b0;
        idx_n     = idx_q;
        nidx_n    = nidx_q;
        done_n    = 1'b0;
        err_n     = 1'b0;

        unique case (state)
            ST_WAIT_GAP: begin
                if (level) begin
                    cnt_n = '0;
                end else if (cnt_inc == GAP_CNT) begin
                    state_n   = ST_IDLE;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    shreg_n   = '0;
                    idx_n     = '0;
                    nidx_n    = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_HIGH;
                    cnt_n   = ONE_CNT;
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    // The falling-edge cycle is already the first low cycle.
                    cnt_n = ONE_CNT;
                    if (cnt < MIN_CNT) begin
                        err_n   = 1'b1;
                        state_n = ST_WAIT_GAP;
                    end else begin
                        state_n = ST_LOW;
                        shreg_n = shifted;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt_n = '0;
                            data_n    = shifted;
                            valid_n   = 1'b1;
                            idx_n     = nidx_q;
                            nidx_n    = (nidx_q == 8'hFF) ? nidx_q
                                                          : nidx_q + 8'd1;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end
                end else if (cnt_inc == OVR_CNT) begin
                    err_n   = 1'b1;
                    state_n = ST_WAIT_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            ST_LOW: begin
                if (rise) begin
                    state_n = ST_HIGH;
                    cnt_n   = ONE_CNT;
                end else if (cnt_inc == GAP_CNT) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    // nidx_q is nonzero exactly when a word was emitted.
                    if (bit_cnt != '0) begin
                        err_n = 1'b1;
                    end else if (nidx_q != '0) begin
                        done_n = 1'b1;
                    end
                    bit_cnt_n = '0;
                    shreg_n   = '0;
                    idx_n     = '0;
                    nidx_n    = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            default: begin
                state_n = ST_WAIT_GAP;
                cnt_n   = '0;
            end
        endcase
    end

    assign rx.rgb_data   = data_q;
    assign rx.rgb_valid  = valid_q;
    assign rx.led_index  = idx_q;
    assign rx.frame_done = done_q;
    assign rx.err        = err_q;

endmodule
